adc_capture: RTL and testbench
==============================

Name: adc_capture

Overview:
- Serial front-end for the receive-path ADC.
- Drives adc_cs and deserialises adc_sdo into parallel samples, clocked by clk48. adc_clk is clk48, driven at top level.
- Samples are offered to the downstream correlator input stage through a one-entry valid/ready holding register.
- Also flags overruns and framing errors (non-zero leading bits).

Parameters:
- DATA_BITS, 12, sample width delivered on sample_data.
- LEAD_BITS, 4, leading zero bits the ADC emits before the MSB.
- QUIET_CLKS, 4, clk48 cycles adc_cs is held high between frames (ADC acquisition time, minimum 1).
- CNT_W, 16, width of the overrun and framing-error counters.

Ports:
- clk48  in  1  system clock, 48 MHz; also the ADC serial clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = run continuous conversions; 0 = finish current frame, then idle.
- adc_cs  out  1  ADC chip select, active-low.
- adc_sdo  in  1  ADC serial data, MSB first, sampled on rising clk48.
- sample_data  out  DATA_BITS  captured sample, unsigned offset-binary as delivered by the ADC.
- sample_valid  out  1  holding register contains an unconsumed sample.
- sample_ready  in  1  downstream accepts; transfer occurs when valid and ready are both 1 on a rising edge.
- overrun_count  out  CNT_W  frames dropped because the holding register was still full; saturates.
- frame_err_count  out  CNT_W  frames with any non-zero leading bit; saturates.
- busy  out  1  1 while state is not IDLE.

Behaviour:
- Reset (reset==0 at a rising edge), all registered:
  - adc_cs=1, sample_data=0, sample_valid=0, overrun_count=0, frame_err_count=0, busy=0.
  - State=IDLE, bit counter=0, shift register=0.
  - Reset mid-frame aborts the frame: no sample is produced and the counters are cleared.
- Frame length is F = LEAD_BITS + DATA_BITS (16 by default).
- State machine:
  - IDLE: adc_cs=1. If enable=1, next state is CONVERT and adc_cs goes 0 on that same edge.
  - CONVERT: adc_cs=0. Bit counter runs 0..F-1. Each rising edge shifts adc_sdo into the LSB of the F-bit shift register.
    - On the edge where counter==F-1, the F-th bit is shifted in and the frame is complete.
    - adc_cs goes 1 on that edge. Next state is QUIET and the quiet counter is loaded with QUIET_CLKS-1.
  - QUIET: adc_cs=1. Count down.
    - At zero, next state is CONVERT (adc_cs=0) if enable=1, else IDLE.
- Frame boundaries:
  - Back-to-back period is F+QUIET_CLKS cycles (20 by default, 2.4 MSPS).
  - Exactly F bits are sampled per adc_cs low period.
- enable deasserted during CONVERT: the frame completes and is delivered normally.
- Frame completion happens on the cycle after the F-th bit is captured:
  - The full frame is the F bits sampled during the CONVERT cycles with counter=0..F-1.
  - Leading bits are frame[F-1 : DATA_BITS]. The data is frame[DATA_BITS-1 : 0].
  - If the leading bits are non-zero, increment frame_err_count (saturating at all-ones). The sample is still delivered.
  - If sample_valid=0, or (sample_valid=1 and sample_ready=1) on that edge: load sample_data and set sample_valid=1.
  - Otherwise drop the new sample, keep the old one, and increment overrun_count (saturating).
- Handshake:
  - sample_valid falls on the edge after acceptance unless a new frame completes on the same edge, in which case it stays 1 with new data.
  - sample_data is stable while sample_valid=1 and sample_ready=0.
- Latency: sample_valid rises 1 cycle after the edge sampling the last data bit (frame completion).
- No combinational path from any input to any output.

Test Plan:
- Reset held low 3 cycles with enable=1 -> adc_cs=1, sample_valid=0, both counters 0; first adc_cs fall on the first edge after reset=1.
- ADC model drives 0000_1010_0101_1010 with sample_ready=1 -> sample_data=12'hA5A, sample_valid one-cycle pulse; adc_cs low exactly 16 cycles, then high 4 cycles; sample_valid pulses 1 cycle after frame completion; frame period 20 cycles.
- Leading bits 0100, data 12'h123 -> sample_data=12'h123, frame_err_count=1.
- sample_ready=0 for 3 frames with data 0x001, 0x002, 0x003 -> sample_data stays 0x001, overrun_count=2; ready=1 then gives one transfer of 0x001.
- Ready=1 on the exact completion edge with valid=1 and new data 0xFFF -> valid stays 1, data=0xFFF, overrun_count unchanged.
- enable dropped mid-frame (bit 7) -> frame completes and is delivered, QUIET lasts 4 cycles, then IDLE with adc_cs=1 and busy=0. Separately, reset mid-frame -> no sample, adc_cs=1 on the next edge.

Source files
------------

// File: rtl/adc_capture.sv
// Serial ADC front-end: drives chip select, deserialises the ADC data stream into samples.
// Latency: sample_valid rises one clk48 cycle after the edge that samples the last data bit.
// Backpressure: one-entry holding register; a frame completing while it is still full is dropped and counted.
module adc_capture #(
  parameter int DATA_BITS  = 12,
  parameter int LEAD_BITS  = 4,
  parameter int QUIET_CLKS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk48,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 adc_cs,
  input  logic                 adc_sdo,
  output logic [DATA_BITS-1:0] sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic [CNT_W-1:0]     overrun_count,
  output logic [CNT_W-1:0]     frame_err_count,
  output logic                 busy
);

  localparam int F  = LEAD_BITS + DATA_BITS;
  localparam int BW = $clog2(F);
  localparam int QW = (QUIET_CLKS > 1) ? $clog2(QUIET_CLKS) : 1;
  localparam logic [BW-1:0] LAST_BIT   = BW'(F - 1);
  localparam logic [QW-1:0] QUIET_LOAD = QW'(QUIET_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_QUIET
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_cs;
  logic                 w_cs_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic [BW-1:0]        r_bit_cnt;
  logic [QW-1:0]        r_quiet_cnt;
  logic [F-1:0]         r_shift;
  logic                 r_done;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic [CNT_W-1:0]     r_ovr_cnt;
  logic [CNT_W-1:0]     r_ferr_cnt;
  logic                 w_frame_last;
  logic                 w_lead_err;
  logic                 w_load;

  // The edge that samples the F-th bit closes the frame.
  assign w_frame_last = (r_state == S_CONVERT) && (r_bit_cnt == LAST_BIT);

  // Next-state decode; chip select and busy are registered from the next state so they change on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (enable) w_state_nxt = S_CONVERT;
      S_CONVERT: if (r_bit_cnt == LAST_BIT) w_state_nxt = S_QUIET;
      S_QUIET:   if (r_quiet_cnt == '0) w_state_nxt = enable ? S_CONVERT : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    w_cs_nxt   = (w_state_nxt != S_CONVERT);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State register with registered chip select and busy.
  always_ff @(posedge clk48) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cs    <= w_cs_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Bit capture, bit/quiet counters and the one-cycle frame-done flag.
  always_ff @(posedge clk48) begin
    if (!reset) begin
      r_bit_cnt   <= '0;
      r_quiet_cnt <= '0;
      r_shift     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_frame_last;
      if (r_state == S_CONVERT) begin
        r_shift   <= {r_shift[F-2:0], adc_sdo};
        r_bit_cnt <= w_frame_last ? '0 : r_bit_cnt + 1'b1;
      end
      if (w_frame_last) begin
        r_quiet_cnt <= QUIET_LOAD;
      end else if ((r_state == S_QUIET) && (r_quiet_cnt != '0)) begin
        r_quiet_cnt <= r_quiet_cnt - 1'b1;
      end
    end
  end

  // A completed frame loads if the holding register is empty or being drained on this edge.
  assign w_lead_err = |r_shift[F-1:DATA_BITS];
  assign w_load     = r_done && (!r_valid || sample_ready);

  // Holding register and saturating overrun / framing-error counters.
  always_ff @(posedge clk48) begin
    if (!reset) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ovr_cnt  <= '0;
      r_ferr_cnt <= '0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift[DATA_BITS-1:0];
        r_valid <= 1'b1;
      end else if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
      if (r_done && !w_load && (r_ovr_cnt != '1)) begin
        r_ovr_cnt <= r_ovr_cnt + 1'b1;
      end
      if (r_done && w_lead_err && (r_ferr_cnt != '1)) begin
        r_ferr_cnt <= r_ferr_cnt + 1'b1;
      end
    end
  end

  assign adc_cs          = r_cs;
  assign busy            = r_busy;
  assign sample_data     = r_data;
  assign sample_valid    = r_valid;
  assign overrun_count   = r_ovr_cnt;
  assign frame_err_count = r_ferr_cnt;

endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: ADC serial model, scoreboard on accepted samples, table of frames plus corner sequences.
// Counters are built 2 bits wide so saturation is reachable with a handful of errored frames.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or on the falling edge.
module tb_adc_capture;

  localparam int DATA_BITS = 12;
  localparam int LEAD_BITS = 4;
  localparam int QUIET     = 4;
  localparam int CNT_W     = 2;

  typedef struct {
    logic [15:0] frame;
    logic [11:0] exp_data;
    logic        lead_err;
  } vec_t;

  typedef struct {
    logic [11:0] data;
    int          ferr;
  } sb_t;

  logic                 clk48;
  logic                 reset;
  logic                 enable;
  logic                 adc_cs;
  logic                 adc_sdo;
  logic [DATA_BITS-1:0] sample_data;
  logic                 sample_valid;
  logic                 sample_ready;
  logic [CNT_W-1:0]     overrun_count;
  logic [CNT_W-1:0]     frame_err_count;
  logic                 busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_xfer   = 0;
  int   exp_ferr = 0;
  bit   sb_en    = 1'b1;
  vec_t adc_q[$];
  sb_t  sb_q[$];
  vec_t cur;
  int   idx = 0;

  adc_capture #(
    .DATA_BITS(DATA_BITS),
    .LEAD_BITS(LEAD_BITS),
    .QUIET_CLKS(QUIET),
    .CNT_W(CNT_W)
  ) dut (
    .clk48(clk48),
    .reset(reset),
    .enable(enable),
    .adc_cs(adc_cs),
    .adc_sdo(adc_sdo),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun_count(overrun_count),
    .frame_err_count(frame_err_count),
    .busy(busy)
  );

  initial clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk48);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      tick(1);
    end
    check("idle_wait", busy, 0);
  endtask

  // ADC model: while chip select is low, present the next frame bit MSB first on each falling edge.
  always @(negedge clk48) begin
    if (adc_cs) begin
      idx     = 0;
      adc_sdo = 1'b0;
    end else begin
      if (idx == 0) begin
        if (adc_q.size() > 0) cur = adc_q.pop_front();
        else cur = '{16'h0000, 12'h000, 1'b0};
        if (cur.lead_err && exp_ferr < 3) exp_ferr++;
        if (sb_en) sb_q.push_back('{cur.exp_data, exp_ferr});
      end
      if (idx < 16) adc_sdo = cur.frame[15-idx];
      idx++;
    end
  end

  // Scoreboard: every accepted sample is compared with the oldest expected entry.
  always @(negedge clk48) begin
    if (sb_en && reset && sample_valid && sample_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_sample", 1, 0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_data", sample_data, e.data);
        check("sb_frame_err", frame_err_count, e.ferr);
      end
      n_xfer++;
    end
  end

  vec_t tbl[7];
  logic cs_log[140];
  logic val_log[140];

  initial begin
    tbl[0] = '{16'h0A5A, 12'hA5A, 1'b0};
    tbl[1] = '{16'h4123, 12'h123, 1'b1};
    tbl[2] = '{16'h0000, 12'h000, 1'b0};
    tbl[3] = '{16'hFFFF, 12'hFFF, 1'b1};
    tbl[4] = '{16'h8001, 12'h001, 1'b1};
    tbl[5] = '{16'h0FFF, 12'hFFF, 1'b0};
    tbl[6] = '{16'h1800, 12'h800, 1'b1};

    reset        = 1'b0;
    enable       = 1'b1;
    sample_ready = 1'b1;
    adc_sdo      = 1'b0;
    for (int i = 0; i < 7; i++) adc_q.push_back(tbl[i]);

    // Reset held three cycles with enable high.
    tick(3);
    check("rst_cs", adc_cs, 1);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_ovr", overrun_count, 0);
    check("rst_ferr", frame_err_count, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    // Continuous run over the frame table, logging chip select and valid per cycle.
    for (int k = 0; k < 140; k++) begin
      tick(1);
      cs_log[k]  = adc_cs;
      val_log[k] = sample_valid;
    end
    enable = 1'b0;
    begin
      int lows = 0;
      for (int k = 0; k < 20; k++) if (!cs_log[k]) lows++;
      check("cs_first_fall", cs_log[0], 0);
      check("cs_low_cycles", lows, 16);
    end
    check("cs_rise_at_16", cs_log[16], 1);
    check("cs_quiet_end", cs_log[19], 1);
    check("cs_period_20", cs_log[20], 0);
    check("valid_before", val_log[16], 0);
    check("valid_pulse", val_log[17], 1);
    check("valid_after", val_log[18], 0);
    check("valid_frame2", val_log[37], 1);
    wait_idle();
    check("table_xfers", n_xfer, 7);
    check("table_sb_empty", sb_q.size(), 0);
    check("ferr_saturated", frame_err_count, 3);
    check("table_ovr", overrun_count, 0);

    // Three frames with ready low: first sample held, two overruns.
    sb_en        = 1'b0;
    sample_ready = 1'b0;
    adc_q.push_back('{16'h0001, 12'h001, 1'b0});
    adc_q.push_back('{16'h0002, 12'h002, 1'b0});
    adc_q.push_back('{16'h0003, 12'h003, 1'b0});
    enable = 1'b1;
    tick(45);
    enable = 1'b0;
    tick(17);
    check("ovr_held_data", sample_data, 12'h001);
    check("ovr_held_valid", sample_valid, 1);
    check("ovr_count", overrun_count, 2);
    check("ovr_idle", busy, 0);
    sample_ready = 1'b1;
    tick(1);
    check("ovr_drain_valid", sample_valid, 0);
    tick(3);
    check("ovr_no_more", sample_valid, 0);

    // Ready rises exactly on the completion edge of a new frame while full.
    sample_ready = 1'b0;
    adc_q.push_back('{16'h0005, 12'h005, 1'b0});
    adc_q.push_back('{16'h0FFF, 12'hFFF, 1'b0});
    enable = 1'b1;
    tick(25);
    enable = 1'b0;
    tick(12);
    check("cmp_pre_valid", sample_valid, 1);
    check("cmp_pre_data", sample_data, 12'h005);
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    check("cmp_valid", sample_valid, 1);
    check("cmp_data", sample_data, 12'hFFF);
    check("cmp_ovr", overrun_count, 2);
    tick(1);
    check("cmp_stable", sample_data, 12'hFFF);
    sample_ready = 1'b1;
    tick(1);
    check("cmp_drained", sample_valid, 0);
    wait_idle();

    // Enable dropped at bit 7: frame still delivered, quiet of 4, then idle.
    sb_en = 1'b1;
    adc_q.push_back('{16'h0777, 12'h777, 1'b0});
    enable = 1'b1;
    tick(8);
    enable = 1'b0;
    tick(9);
    check("en_cs_rise", adc_cs, 1);
    tick(3);
    check("en_quiet_busy", busy, 1);
    tick(1);
    check("en_idle_busy", busy, 0);
    check("en_idle_cs", adc_cs, 1);
    tick(4);
    check("en_stay_idle", adc_cs, 1);
    check("en_xfers", n_xfer, 8);
    check("en_sb_empty", sb_q.size(), 0);

    // Reset in the middle of a frame: aborted, no sample, counters cleared.
    sb_en = 1'b0;
    adc_q.push_back('{16'h0ABC, 12'hABC, 1'b0});
    enable = 1'b1;
    tick(6);
    check("mid_cs_low", adc_cs, 0);
    reset  = 1'b0;
    enable = 1'b0;
    tick(1);
    exp_ferr = 0;
    check("mid_rst_cs", adc_cs, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ferr", frame_err_count, 0);
    check("mid_rst_ovr", overrun_count, 0);
    reset = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 25; k++) begin
        tick(1);
        if (sample_valid) seen++;
      end
      check("mid_rst_no_sample", seen, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
